// File: rtl/egress_frame_reader.sv
// Drains descriptor-tagged frames from the FWFT packet buffer onto an AXI-stream egress port, discarding dropped frames.
// Optional EGRESS_STATS_EN adds saturating transmitted/dropped frame counters.
module egress_frame_reader #(
  parameter int DATA_W = 8,
  parameter int DEST_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              desc_valid,
  input  logic              desc_drop,
  input  logic [DEST_W-1:0] desc_dest,
  output logic              desc_ready,
  input  logic              buf_empty,
  input  logic [DATA_W-1:0] buf_rdata,
  input  logic              buf_rlast,
  output logic              buf_ren,
  output logic              egress_tvalid,
  output logic [DATA_W-1:0] egress_tdata,
  output logic              egress_tlast,
  output logic [DEST_W-1:0] egress_tdest,
  input  logic              egress_tready,
  output logic              busy
`ifdef EGRESS_STATS_EN
  ,
  output logic [CNT_W-1:0]  tx_frame_count,
  output logic [CNT_W-1:0]  drop_frame_count
`endif
);

  typedef enum logic [1:0] {IDLE, FWD, DISCARD} state_t;
  typedef logic [CNT_W-1:0] cnt_t;

  state_t            state, state_nxt;
  logic [DEST_W-1:0] dest_q;
  logic              pop_fwd;
  logic              pop_disc;

  always_comb begin
    state_nxt  = state;
    desc_ready = 1'b0;
    buf_ren    = 1'b0;
    pop_fwd    = 1'b0;
    pop_disc   = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (desc_valid) begin
            desc_ready = 1'b1;
            state_nxt  = desc_drop ? DISCARD : FWD;
          end
        end
        FWD: begin
          // Refill the output register only when it is empty or draining this cycle.
          if (!buf_empty && (!egress_tvalid || egress_tready)) begin
            buf_ren = 1'b1;
            pop_fwd = 1'b1;
            if (buf_rlast) state_nxt = IDLE;
          end
        end
        DISCARD: begin
          if (!buf_empty) begin
            buf_ren  = 1'b1;
            pop_disc = 1'b1;
            if (buf_rlast) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      dest_q        <= '0;
      egress_tvalid <= 1'b0;
      egress_tdata  <= '0;
      egress_tlast  <= 1'b0;
      egress_tdest  <= '0;
    end else begin
      state <= state_nxt;
      if (desc_ready) dest_q <= desc_dest;
      if (pop_fwd) begin
        egress_tvalid <= 1'b1;
        egress_tdata  <= buf_rdata;
        egress_tlast  <= buf_rlast;
        egress_tdest  <= dest_q;
      end else if (egress_tvalid && egress_tready) begin
        egress_tvalid <= 1'b0;
        egress_tdata  <= '0;
        egress_tlast  <= 1'b0;
        egress_tdest  <= '0;
      end
    end
  end

  assign busy = (state != IDLE) || egress_tvalid;

`ifdef EGRESS_STATS_EN
  localparam cnt_t CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_frame_count   <= '0;
      drop_frame_count <= '0;
    end else begin
      if (egress_tvalid && egress_tready && egress_tlast && (tx_frame_count != CNT_MAX))
        tx_frame_count <= tx_frame_count + 1'b1;
      if (pop_disc && buf_rlast && (drop_frame_count != CNT_MAX))
        drop_frame_count <= drop_frame_count + 1'b1;
    end
  end
`endif

endmodule

// File: doc/egress_frame_reader.md
Name: egress_frame_reader

Overview:
- Egress-side counterpart to the ingress processor: drains stored frames from the packet buffer and transmits them on the egress AXI-stream.
- Consumes one descriptor per frame from the descriptor FIFO. The descriptor carries the drop verdict and destination computed at ingress.
- Frames marked drop are popped and discarded. Kept frames are forwarded byte-for-byte with tdest attached.
- Sits between the frame buffer / descriptor FIFO and the switch egress port.

Parameters:
- DATA_W, 8, egress/buffer data width in bits.
- DEST_W, 2, width of destination port index.
- CNT_W, 16, statistics counter width (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- desc_valid  in  1  descriptor FIFO non-empty; descriptor fields valid
- desc_drop  in  1  1 = discard this frame
- desc_dest  in  DEST_W  destination port of this frame
- desc_ready  out  1  pops the descriptor (FWFT FIFO)
- buf_empty  in  1  frame buffer empty (FWFT)
- buf_rdata  in  DATA_W  head byte of frame buffer
- buf_rlast  in  1  head byte is last byte of its frame
- buf_ren  out  1  pops the buffer head
- egress_tvalid  out  1  AXI-stream valid
- egress_tdata  out  DATA_W  AXI-stream data
- egress_tlast  out  1  AXI-stream last
- egress_tdest  out  DEST_W  AXI-stream destination, constant for the whole frame
- egress_tready  in  1  AXI-stream ready from the downstream sink
- busy  out  1  high whenever state != IDLE or the output register is occupied

Behaviour:
- Reset (synchronous, active-high): state = IDLE; output register empty. All outputs are 0: egress_tvalid, egress_tdata, egress_tlast, egress_tdest, desc_ready, buf_ren, busy. Reset mid-frame abandons the frame. Buffer and descriptor contents are not touched.
- Both FIFOs are first-word-fall-through. A pop takes effect at the clock edge where ren/ready is high.
- States:
  - IDLE
    - If desc_valid: assert desc_ready (combinational, one cycle), latch desc_drop and desc_dest.
    - Go to DISCARD if drop, otherwise FWD.
  - FWD
    - pop = !buf_empty && (!egress_tvalid || egress_tready).
    - On pop, load buf_rdata/buf_rlast into the output register, set egress_tvalid = 1 and egress_tdest = latched dest.
    - On a pop with buf_rlast = 1, go to IDLE.
  - DISCARD
    - buf_ren = !buf_empty. Bytes are discarded and egress is untouched.
    - On a pop with buf_rlast = 1, go to IDLE.
- Output register:
  - Cleared when egress_tvalid && egress_tready && no new pop.
  - Holds tdata/tlast/tdest stable while tvalid && !tready (AXI rule).
- Throughput and latency:
  - Full throughput of 1 byte/cycle while tready = 1 and the buffer is non-empty.
  - Latency: descriptor accepted in cycle N; first pop in N+1; egress_tvalid first high in N+2.
  - Minimum of one idle cycle per frame (the IDLE cycle). The IDLE cycle may overlap with the last byte still waiting in the output register.
  - A new descriptor may be accepted in IDLE while the previous frame's last byte is still held.
- Buffer empty mid-frame: stall. buf_ren = 0; egress_tvalid drops once the held byte is consumed. The frame is not aborted.
- tready low with the buffer non-empty: no pop, no data loss.
- Descriptor while not IDLE: ignored; desc_ready = 0.
- Zero-length frames do not exist. Every descriptor corresponds to at least one byte carrying rlast.
- buf_ren is never high when buf_empty = 1. desc_ready is never high when desc_valid = 0.

Optional Feature:
- Macro: EGRESS_STATS_EN.
- Defined:
  - Adds outputs tx_frame_count [CNT_W] and drop_frame_count [CNT_W], both reset to 0.
  - tx_frame_count increments on each egress handshake with tlast = 1.
  - drop_frame_count increments on each DISCARD pop with buf_rlast = 1.
  - Both counters saturate at all-ones; they do not wrap.
- Undefined: ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Kept frame: one descriptor {drop=0, dest=2}, buffer holds bytes 0x11,0x22,0x33 (last on 0x33), tready = 1 -> egress carries 0x11,0x22,0x33 on consecutive cycles starting N+2, tlast only on 0x33, tdest = 2 throughout, then IDLE.
- Dropped frame: descriptor {drop=1}, 4-byte frame, followed by kept frame 0xAA,0xBB -> buffer popped 4 times with egress_tvalid = 0; then 0xAA,0xBB transmitted; with EGRESS_STATS_EN, drop_frame_count = 1 and tx_frame_count = 1.
- Backpressure: 5-byte frame, tready toggles 1,0,0,1,… -> tdata/tlast stable while stalled; exactly 5 handshakes, in order, no duplicates.
- Buffer underrun: 3-byte frame, buf_empty = 1 for 4 cycles after byte 1 -> tvalid low during the gap, frame resumes intact, single tlast.
- Reset mid-frame: assert reset for 1 cycle after byte 2 of 6 -> next cycle all outputs 0, state IDLE; the next descriptor is accepted normally.
- Saturation (EGRESS_STATS_EN, CNT_W = 2): send 5 kept frames -> tx_frame_count ends at 3.
